// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - CPU load/store request to data-memory port controller
// Validates size/alignment, issues one memory access, extends load data, holds response.
module data_mem_ctrl #(
   parameter int MEM_RD_LAT = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [3:0]  req_size,
   input  logic        req_signed,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic [63:0] address,
   output logic        write_enable,
   output logic        read_enable,
   output logic [63:0] write_data,
   output logic [3:0]  xfer_size,
   input  logic [63:0] read_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam logic [1:0] CNT_INIT = (MEM_RD_LAT > 0) ? 2'(MEM_RD_LAT - 1) : 2'd0;
   localparam bit         NO_WAIT  = (MEM_RD_LAT == 0);

   state_e      state_q, state_d;
   logic        wr_q;
   logic        signed_q;
   logic        err_q;
   logic [63:0] rdata_q;
   logic [1:0]  cnt_q;
   logic [63:0] address_q;
   logic [63:0] wdata_q;
   logic [3:0]  size_q;

   logic        size_ok;
   logic        aligned;
   logic        legal;
   logic        accept;
   logic        load_sample;

   function automatic logic [63:0] extend(input logic [63:0] d,
                                          input logic [3:0]  sz,
                                          input logic        sgn);
      logic [63:0] r;
      case (sz)
         4'd1:    r = {{56{sgn & d[7]}},  d[7:0]};
         4'd2:    r = {{48{sgn & d[15]}}, d[15:0]};
         4'd4:    r = {{32{sgn & d[31]}}, d[31:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   always_comb begin
      size_ok = 1'b0;
      aligned = 1'b0;
      case (req_size)
         4'd1: begin size_ok = 1'b1; aligned = 1'b1;                    end
         4'd2: begin size_ok = 1'b1; aligned = (req_addr[0]   == 1'b0);  end
         4'd4: begin size_ok = 1'b1; aligned = (req_addr[1:0] == 2'b00); end
         4'd8: begin size_ok = 1'b1; aligned = (req_addr[2:0] == 3'b000); end
         default: begin size_ok = 1'b0; aligned = 1'b0; end
      endcase
      legal  = size_ok && aligned;
      accept = (state_q == IDLE) && req_valid;
   end

   // The load's final access cycle: end of ISSUE when there is no wait, else last WAIT cycle.
   always_comb begin
      load_sample = 1'b0;
      if (!wr_q) begin
         if (state_q == ISSUE && NO_WAIT)
            load_sample = 1'b1;
         else if (state_q == WAIT && cnt_q == 2'd0)
            load_sample = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid)
               state_d = legal ? ISSUE : RESP;
         end
         ISSUE: begin
            if (wr_q || NO_WAIT)
               state_d = RESP;
            else
               state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == 2'd0)
               state_d = RESP;
         end
         RESP: begin
            if (resp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready    = (state_q == IDLE);
      resp_valid   = (state_q == RESP);
      resp_err     = (state_q == RESP) && err_q;
      resp_rdata   = (state_q == RESP) ? rdata_q : 64'd0;
      write_enable = (state_q == ISSUE) && wr_q;
      read_enable  = (state_q == ISSUE) && !wr_q;
   end

   // Memory-port fields only change for legal requests so they hold their last driven values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_q      <= 1'b0;
         signed_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= 64'd0;
         cnt_q     <= 2'd0;
         address_q <= 64'd0;
         wdata_q   <= 64'd0;
         size_q    <= 4'd0;
      end else begin
         if (accept) begin
            wr_q     <= req_write;
            signed_q <= req_signed;
            err_q    <= !legal;
            rdata_q  <= 64'd0;
            if (legal) begin
               address_q <= req_addr;
               wdata_q   <= req_wdata;
               size_q    <= req_size;
            end
         end
         if (state_q == ISSUE)
            cnt_q <= CNT_INIT;
         else if (state_q == WAIT && cnt_q != 2'd0)
            cnt_q <= cnt_q - 2'd1;
         if (load_sample)
            rdata_q <= extend(read_data, size_q, signed_q);
      end
   end

   assign address    = address_q;
   assign write_data = wdata_q;
   assign xfer_size  = size_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;
   parameter int MEM_RD_LAT = 1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [3:0]  req_size;
   logic        req_signed;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic [63:0] address;
   logic        write_enable;
   logic        read_enable;
   logic [63:0] write_data;
   logic [3:0]  xfer_size;
   logic [63:0] read_data;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   data_mem_ctrl #(.MEM_RD_LAT(MEM_RD_LAT)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .address(address),
      .write_enable(write_enable), .read_enable(read_enable),
      .write_data(write_data), .xfer_size(xfer_size), .read_data(read_data)
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic send(input logic wr, input logic [3:0] sz, input logic sg,
                       input logic [63:0] a, input logic [63:0] wd);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      step();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
      req_write = 1'b0; req_size = 4'd0; req_signed = 1'b0;
      req_addr = 64'd0; req_wdata = 64'd0; read_data = 64'd0;
      step(); step();
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", req_ready); else pass_cnt++;
      total_cnt++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); else pass_cnt++;
      total_cnt++; if (resp_err !== 1'b0) $display("FAIL reset_resp_err: got %b expected 0", resp_err); else pass_cnt++;
      total_cnt++; if (resp_rdata !== 64'd0) $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); else pass_cnt++;
      total_cnt++; if ({write_enable, read_enable} !== 2'b00) $display("FAIL reset_enables: got %b expected 00", {write_enable, read_enable}); else pass_cnt++;
      total_cnt++; if (address !== 64'd0) $display("FAIL reset_address: got %h expected 0", address); else pass_cnt++;
      total_cnt++; if (write_data !== 64'd0) $display("FAIL reset_write_data: got %h expected 0", write_data); else pass_cnt++;
      total_cnt++; if (xfer_size !== 4'd0) $display("FAIL reset_xfer_size: got %h expected 0", xfer_size); else pass_cnt++;
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_store();
      send(1'b1, 4'd8, 1'b0, 64'h10, 64'hDEADBEEF_CAFEF00D);
      total_cnt++; if (write_enable !== 1'b1) $display("FAIL store_we: got %b expected 1", write_enable); else pass_cnt++;
      total_cnt++; if (read_enable !== 1'b0) $display("FAIL store_re: got %b expected 0", read_enable); else pass_cnt++;
      total_cnt++; if (address !== 64'h10) $display("FAIL store_address: got %h expected 10", address); else pass_cnt++;
      total_cnt++; if (xfer_size !== 4'd8) $display("FAIL store_xfer_size: got %h expected 8", xfer_size); else pass_cnt++;
      total_cnt++; if (write_data !== 64'hDEADBEEF_CAFEF00D) $display("FAIL store_write_data: got %h expected deadbeefcafef00d", write_data); else pass_cnt++;
      step();
      total_cnt++; if (resp_valid !== 1'b1) $display("FAIL store_resp_valid: got %b expected 1", resp_valid); else pass_cnt++;
      total_cnt++; if (resp_err !== 1'b0) $display("FAIL store_resp_err: got %b expected 0", resp_err); else pass_cnt++;
      total_cnt++; if (resp_rdata !== 64'd0) $display("FAIL store_resp_rdata: got %h expected 0", resp_rdata); else pass_cnt++;
      total_cnt++; if (write_enable !== 1'b0) $display("FAIL store_we_single: got %b expected 0", write_enable); else pass_cnt++;
      total_cnt++; if (address !== 64'h10) $display("FAIL store_address_hold: got %h expected 10", address); else pass_cnt++;
      step();
      total_cnt++; if ({req_ready, resp_valid} !== 2'b10) $display("FAIL store_back_idle: got %b expected 10", {req_ready, resp_valid}); else pass_cnt++;
   endtask

   task automatic test_load(input string name, input logic [3:0] sz, input logic sg,
                            input logic [63:0] a, input logic [63:0] rd, input logic [63:0] exp);
      int n;
      int re_cnt;
      int we_cnt;
      send(1'b0, sz, sg, a, 64'h0);
      total_cnt++; if (address !== a) $display("FAIL %s_address: got %h expected %h", name, address, a); else pass_cnt++;
      total_cnt++; if (xfer_size !== sz) $display("FAIL %s_xfer_size: got %h expected %h", name, xfer_size, sz); else pass_cnt++;
      n = 0; re_cnt = 0; we_cnt = 0;
      // Only the sampling cycle presents the real data; every other cycle presents its complement.
      while (resp_valid !== 1'b1 && n < 12) begin
         if (read_enable === 1'b1) re_cnt++;
         if (write_enable === 1'b1) we_cnt++;
         read_data = (n == MEM_RD_LAT) ? rd : ~rd;
         step();
         n++;
      end
      total_cnt++; if (n !== MEM_RD_LAT + 1) $display("FAIL %s_latency: got %0d expected %0d", name, n, MEM_RD_LAT + 1); else pass_cnt++;
      total_cnt++; if (re_cnt !== 1 || we_cnt !== 0) $display("FAIL %s_enables: got re=%0d we=%0d expected re=1 we=0", name, re_cnt, we_cnt); else pass_cnt++;
      total_cnt++; if (resp_rdata !== exp) $display("FAIL %s_rdata: got %h expected %h", name, resp_rdata, exp); else pass_cnt++;
      total_cnt++; if (resp_err !== 1'b0) $display("FAIL %s_err: got %b expected 0", name, resp_err); else pass_cnt++;
      step();
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL %s_idle: got %b expected 1", name, req_ready); else pass_cnt++;
   endtask

   task automatic test_error(input string name, input logic wr, input logic [3:0] sz,
                             input logic [63:0] a, input logic [63:0] hold_addr);
      int en_cnt;
      en_cnt = 0;
      send(wr, sz, 1'b1, a, 64'hFFFF_FFFF_FFFF_FFFF);
      if (write_enable === 1'b1 || read_enable === 1'b1) en_cnt++;
      total_cnt++; if (resp_valid !== 1'b1) $display("FAIL %s_resp_valid: got %b expected 1", name, resp_valid); else pass_cnt++;
      total_cnt++; if (resp_err !== 1'b1) $display("FAIL %s_resp_err: got %b expected 1", name, resp_err); else pass_cnt++;
      total_cnt++; if (resp_rdata !== 64'd0) $display("FAIL %s_resp_rdata: got %h expected 0", name, resp_rdata); else pass_cnt++;
      total_cnt++; if (address !== hold_addr) $display("FAIL %s_address_hold: got %h expected %h", name, address, hold_addr); else pass_cnt++;
      step();
      if (write_enable === 1'b1 || read_enable === 1'b1) en_cnt++;
      total_cnt++; if (en_cnt !== 0) $display("FAIL %s_no_access: got %0d enable cycles expected 0", name, en_cnt); else pass_cnt++;
      total_cnt++; if ({req_ready, resp_err} !== 2'b10) $display("FAIL %s_idle: got %b expected 10", name, {req_ready, resp_err}); else pass_cnt++;
   endtask

   task automatic test_store_signed();
      send(1'b1, 4'd2, 1'b1, 64'h40, 64'h0000_0000_0000_8001);
      total_cnt++; if ({write_enable, read_enable} !== 2'b10) $display("FAIL sstore_enables: got %b expected 10", {write_enable, read_enable}); else pass_cnt++;
      total_cnt++; if (write_data !== 64'h8001) $display("FAIL sstore_write_data: got %h expected 8001", write_data); else pass_cnt++;
      step();
      total_cnt++; if ({resp_valid, resp_err} !== 2'b10) $display("FAIL sstore_resp: got %b expected 10", {resp_valid, resp_err}); else pass_cnt++;
      total_cnt++; if (resp_rdata !== 64'd0) $display("FAIL sstore_rdata: got %h expected 0", resp_rdata); else pass_cnt++;
      step();
   endtask

   task automatic test_back_to_back();
      int n;
      resp_ready = 1'b0;
      read_data = 64'hA5A5_5A5A_0123_4567;
      send(1'b0, 4'd8, 1'b0, 64'h28, 64'h0);
      n = 0;
      while (resp_valid !== 1'b1 && n < 12) begin step(); n++; end
      total_cnt++; if (resp_valid !== 1'b1) $display("FAIL bp_resp_timeout: got %b expected 1", resp_valid); else pass_cnt++;
      req_valid = 1'b1; req_write = 1'b1; req_size = 4'd8; req_signed = 1'b0;
      req_addr = 64'h30; req_wdata = 64'h1357_9BDF_0246_8ACE;
      for (int i = 0; i < 5; i++) begin
         total_cnt++; if (resp_valid !== 1'b1 || resp_rdata !== 64'hA5A5_5A5A_0123_4567) $display("FAIL bp_hold_%0d: got valid=%b rdata=%h expected valid=1 rdata=a5a55a5a01234567", i, resp_valid, resp_rdata); else pass_cnt++;
         total_cnt++; if ({req_ready, write_enable, read_enable} !== 3'b000) $display("FAIL bp_ignore_%0d: got %b expected 000", i, {req_ready, write_enable, read_enable}); else pass_cnt++;
         step();
      end
      resp_ready = 1'b1;
      step();
      total_cnt++; if ({req_ready, resp_valid, write_enable} !== 3'b100) $display("FAIL bp_idle_gap: got %b expected 100", {req_ready, resp_valid, write_enable}); else pass_cnt++;
      step();
      req_valid = 1'b0;
      total_cnt++; if (write_enable !== 1'b1 || address !== 64'h30) $display("FAIL bp_next_issue: got we=%b addr=%h expected we=1 addr=30", write_enable, address); else pass_cnt++;
      step();
      step();
   endtask

   task automatic test_reset_wait();
      int seen;
      read_data = 64'h0;
      send(1'b0, 4'd1, 1'b0, 64'h5, 64'h0);
      if (MEM_RD_LAT > 0) step();
      reset_n = 1'b0;
      step();
      total_cnt++; if ({req_ready, resp_valid, read_enable} !== 3'b100) $display("FAIL rst_wait_idle: got %b expected 100", {req_ready, resp_valid, read_enable}); else pass_cnt++;
      total_cnt++; if (address !== 64'd0) $display("FAIL rst_wait_address: got %h expected 0", address); else pass_cnt++;
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (resp_valid === 1'b1 || read_enable === 1'b1) seen++;
         step();
      end
      total_cnt++; if (seen !== 0) $display("FAIL rst_wait_no_resp: got %0d active cycles expected 0", seen); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_store();
      test_load("ld_b_s",  4'd1, 1'b1, 64'h3,  64'h1122_3344_5566_7780, 64'hFFFF_FFFF_FFFF_FF80);
      test_load("ld_b_u",  4'd1, 1'b0, 64'h3,  64'h1122_3344_5566_7780, 64'h0000_0000_0000_0080);
      test_load("ld_h_s",  4'd2, 1'b1, 64'h6,  64'h1122_3344_5566_8001, 64'hFFFF_FFFF_FFFF_8001);
      test_load("ld_w_u",  4'd4, 1'b0, 64'h8,  64'h1122_3344_89AB_CDEF, 64'h0000_0000_89AB_CDEF);
      test_load("ld_w_s",  4'd4, 1'b1, 64'hC,  64'h1122_3344_89AB_CDEF, 64'hFFFF_FFFF_89AB_CDEF);
      test_load("ld_d",    4'd8, 1'b1, 64'h18, 64'h8877_6655_4433_2211, 64'h8877_6655_4433_2211);
      test_load("ld_h_sp", 4'd2, 1'b1, 64'h2,  64'hFFFF_FFFF_FFFF_7FFE, 64'h0000_0000_0000_7FFE);
      test_error("err_misalign_w", 1'b0, 4'd4, 64'h6,  64'h2);
      test_error("err_size3",      1'b1, 4'd3, 64'h20, 64'h2);
      test_error("err_misalign_d", 1'b1, 4'd8, 64'h4,  64'h2);
      test_error("err_size0",      1'b0, 4'd0, 64'h0,  64'h2);
      test_store_signed();
      test_back_to_back();
      test_reset_wait();
      test_store();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Parameters
REQ-001 SHALL provide parameter MEM_RD_LAT, default 1: cycles from the read-issue cycle to the cycle whose ending clock edge samples read_data (range 0..3).

Interface
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  CPU request present.
REQ-005 SHALL have port req_ready  output  1  controller can accept a request.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  4  transfer bytes; legal values are 1, 2, 4, 8.
REQ-008 SHALL have port req_signed  input  1  sign-extend load data when 1.
REQ-009 SHALL have port req_addr  input  64  byte address.
REQ-010 SHALL have port req_wdata  input  64  store data, LSB-aligned.
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  CPU accepts response.
REQ-013 SHALL have port resp_rdata  output  64  extended load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  illegal size or misaligned address.
REQ-015 SHALL have ports address  output  64, write_enable  output  1, read_enable  output  1, write_data  output  64, xfer_size  output  4, read_data  input  64: the datamem port (controller is initiator).

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-018 SHALL on acceptance register req_write, req_size, req_signed, req_addr, req_wdata, and go to RESP with resp_err=1 if req_size is not in {1,2,4,8} or req_addr mod req_size != 0, otherwise to ISSUE.
REQ-019 SHALL on an error make no memory access (write_enable = read_enable = 0 throughout).
REQ-020 SHALL in ISSUE, for exactly one cycle, drive address, xfer_size and write_data from the registered request, and drive write_enable=req_write and read_enable=!req_write.
REQ-021 SHALL go ISSUE->RESP for stores; for loads go ISSUE->WAIT when MEM_RD_LAT>0, or ISSUE->RESP when MEM_RD_LAT=0.
REQ-022 SHALL remain in WAIT for exactly MEM_RD_LAT cycles (counter), then go to RESP.
REQ-023 SHALL for loads sample read_data on the edge leaving the final ISSUE/WAIT cycle.
REQ-024 SHALL extend the low req_size*8 bits of the sampled data to 64 bits: sign-extend if req_signed, else zero-extend; size 8 passes through unchanged.
REQ-025 SHALL hold resp_valid=1 with stable resp_rdata and resp_err in RESP until resp_ready=1, then return to IDLE on that edge.
REQ-026 SHALL return to IDLE and not accept a new request in the same cycle as resp_ready; back-to-back minimum spacing is one IDLE cycle.
REQ-027 SHALL hold address, xfer_size and write_data at their last driven values outside ISSUE, with both enables 0.
REQ-028 SHALL give a store with req_signed=1 no effect beyond the store itself.
REQ-029 SHALL never assert write_enable and read_enable in the same cycle.

Reset
REQ-030 SHALL when reset_n=0 at an edge enter IDLE and set req_ready=1 and resp_valid=0, resp_err=0, resp_rdata=0, write_enable=0, read_enable=0, address=0, write_data=0, xfer_size=0, and clear the WAIT counter.
REQ-031 SHALL let reset mid-ISSUE/WAIT/RESP abandon the transaction: no response is produced, and enables are 0 from the reset edge onward.

Verification
REQ-032 SHALL cover this scenario: store size 8, addr 0x10, wdata 0xDEADBEEF_CAFEF00D -> one ISSUE cycle with write_enable=1, address=0x10, xfer_size=8; next cycle resp_valid=1, resp_err=0, resp_rdata=0.
REQ-033 SHALL cover this scenario: load size 1 signed, addr 0x3, read_data=0x...0080, MEM_RD_LAT=1 -> read_enable for 1 cycle; resp_valid 2 cycles after ISSUE; resp_rdata=0xFFFF_FFFF_FFFF_FF80 (unsigned: 0x80).
REQ-034 SHALL cover this scenario: load size 4, addr 0x6 -> resp_err=1, resp_rdata=0, both enables never asserted.
REQ-035 SHALL cover this scenario: req_size=3 -> resp_err=1, no memory access.
REQ-036 SHALL cover this scenario: resp_ready held 0 for 5 cycles -> resp_valid and data stable 5 cycles, req_ready=0, req_valid ignored; resp_ready=1 -> IDLE next cycle.
REQ-037 SHALL cover this scenario: reset_n=0 during WAIT -> next cycle IDLE, read_enable=0, no resp_valid ever for that request; MEM_RD_LAT=0 and 3 builds re-run REQ-033.
